// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: issues sequential aligned reads (one outstanding at most)
// into a small FIFO of decoded-address entries, with redirect flush and fault halt.
module instr_prefetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 64,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_IP = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    output logic [ADDR_W-1:0]  o_mem_address,
    output logic               o_mem_read,
    input  logic               i_mem_valid,
    input  logic [INSTR_W-1:0] i_mem_data,
    input  logic               i_error_not_present,
    input  logic               i_error_not_user,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_ip,
    output logic               o_instr_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_instr_ip,
    output logic               o_instr_fault,
    input  logic               i_instr_ready,
    output logic [1:0]         o_state
);

    localparam int STEP  = INSTR_W / 8;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] STEP_A     = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(STEP - 1));
    localparam logic [ADDR_W-1:0] START_IP   = RESET_IP & ALIGN_MASK;
    localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    state_t             state, state_d;
    logic [ADDR_W-1:0]  fetch_ip, fetch_ip_d;
    logic [ADDR_W-1:0]  mem_addr, mem_addr_d;

    logic [INSTR_W-1:0] data_mem  [DEPTH];
    logic [ADDR_W-1:0]  ip_mem    [DEPTH];
    logic               fault_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               push, push_fault, pop, mem_err;
    logic [ADDR_W-1:0]  redirect_aligned, fetch_inc;
    logic [CNT_W:0]     cnt_pop, cnt_push_pop;
    logic               room_idle, room_push;

    // Consumer handshake: the head entry transfers on any edge where
    // o_instr_valid and i_instr_ready are both high; a redirect in that
    // cycle wins and the pop is ignored because the queue is flushed.
    assign o_instr_valid = (count != '0);
    assign o_instr       = o_instr_valid ? data_mem[rd_ptr] : '0;
    assign o_instr_ip    = o_instr_valid ? ip_mem[rd_ptr] : '0;
    assign o_instr_fault = o_instr_valid & fault_mem[rd_ptr];

    assign o_mem_read    = (state == ST_REQ) || (state == ST_DISCARD);
    assign o_mem_address = mem_addr;
    assign o_state       = state;

    assign pop              = o_instr_valid & i_instr_ready & ~i_redirect;
    assign mem_err          = i_error_not_present | i_error_not_user;
    assign redirect_aligned = i_redirect_ip & ALIGN_MASK;
    assign fetch_inc        = fetch_ip + STEP_A;

    // A read may issue only if its result is certain to find a free slot,
    // counting any push and pop that land on the same edge.
    assign cnt_pop      = {1'b0, count} - {{CNT_W{1'b0}}, pop};
    assign cnt_push_pop = cnt_pop + (CNT_W + 1)'(1);
    assign room_idle    = (cnt_pop < DEPTH_C);
    assign room_push    = (cnt_push_pop < DEPTH_C);

    always_comb begin
        state_d    = state;
        fetch_ip_d = fetch_ip;
        mem_addr_d = mem_addr;
        push       = 1'b0;
        push_fault = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_redirect) begin
                    fetch_ip_d = redirect_aligned;
                end else if (i_enable && room_idle) begin
                    mem_addr_d = fetch_ip;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_mem_valid) begin
                    if (i_redirect) begin
                        fetch_ip_d = redirect_aligned;
                        state_d    = ST_IDLE;
                    end else if (mem_err) begin
                        push       = 1'b1;
                        push_fault = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        push       = 1'b1;
                        fetch_ip_d = fetch_inc;
                        if (i_enable && room_push) begin
                            mem_addr_d = fetch_inc;
                            state_d    = ST_REQ;
                        end else begin
                            state_d    = ST_IDLE;
                        end
                    end
                end else if (i_redirect) begin
                    fetch_ip_d = redirect_aligned;
                    state_d    = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (i_redirect) begin
                    fetch_ip_d = redirect_aligned;
                end
                if (i_mem_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (i_redirect) begin
                    fetch_ip_d = redirect_aligned;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            fetch_ip <= START_IP;
            mem_addr <= START_IP;
        end else begin
            state    <= state_d;
            fetch_ip <= fetch_ip_d;
            mem_addr <= mem_addr_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge i_clk) begin
        if (push) begin
            data_mem[wr_ptr]  <= push_fault ? '0 : i_mem_data;
            ip_mem[wr_ptr]    <= fetch_ip;
            fault_mem[wr_ptr] <= push_fault;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit: a latency-configurable memory model,
// a head-of-queue scoreboard, and a second DEPTH=8/INSTR_W=32 instance.
module tb_instr_prefetch_unit;

    typedef logic [96:0] v_t;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_HALT    = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic [31:0] o_mem_address;
    logic        o_mem_read;
    logic        i_mem_valid;
    logic [63:0] mem_data;
    logic        err_np, err_nu;
    logic        i_redirect;
    logic [31:0] i_redirect_ip;
    logic        o_instr_valid;
    logic [63:0] o_instr;
    logic [31:0] o_instr_ip;
    logic        o_instr_fault;
    logic        i_instr_ready;
    logic [1:0]  o_state;

    logic        u2_enable, u2_ready, u2_go;
    logic [31:0] u2_mem_address, u2_mem_data, u2_instr, u2_instr_ip;
    logic        u2_mem_read, u2_mem_valid, u2_instr_valid, u2_instr_fault;
    logic [1:0]  u2_state;

    int          n_cmp = 0;
    int          n_fail = 0;
    v_t          exp_q[$];
    logic [31:0] rd_log[$];
    int          mem_lat = 2;
    bit          err_en = 1'b0;
    bit          err_sel = 1'b0;
    logic [31:0] err_addr = '0;
    int          wait_cnt;

    always #5 clk = ~clk;

    instr_prefetch_unit u_dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_enable            (i_enable),
        .o_mem_address       (o_mem_address),
        .o_mem_read          (o_mem_read),
        .i_mem_valid         (i_mem_valid),
        .i_mem_data          (mem_data),
        .i_error_not_present (err_np),
        .i_error_not_user    (err_nu),
        .i_redirect          (i_redirect),
        .i_redirect_ip       (i_redirect_ip),
        .o_instr_valid       (o_instr_valid),
        .o_instr             (o_instr),
        .o_instr_ip          (o_instr_ip),
        .o_instr_fault       (o_instr_fault),
        .i_instr_ready       (i_instr_ready),
        .o_state             (o_state)
    );

    instr_prefetch_unit #(.ADDR_W(32), .INSTR_W(32), .DEPTH(8)) u_dut8 (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_enable            (u2_enable),
        .o_mem_address       (u2_mem_address),
        .o_mem_read          (u2_mem_read),
        .i_mem_valid         (u2_mem_valid),
        .i_mem_data          (u2_mem_data),
        .i_error_not_present (1'b0),
        .i_error_not_user    (1'b0),
        .i_redirect          (1'b0),
        .i_redirect_ip       (32'd0),
        .o_instr_valid       (u2_instr_valid),
        .o_instr             (u2_instr),
        .o_instr_ip          (u2_instr_ip),
        .o_instr_fault       (u2_instr_fault),
        .i_instr_ready       (u2_ready),
        .o_state             (u2_state)
    );

    // Zero-wait memory for the narrow instance.
    assign u2_mem_valid = u2_mem_read & u2_go;
    assign u2_mem_data  = u2_mem_address ^ 32'h5A5A_0000;

    function automatic logic [63:0] data_of(input logic [31:0] a);
        return {a ^ 32'hC0DE_5A5A, ~a};
    endfunction

    task automatic chk(input string tag, input v_t obs, input v_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [31:0] ip, input logic f);
        exp_q.push_back({f, ip, f ? 64'd0 : data_of(ip)});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        i_instr_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        i_instr_ready = 1'b0;
        chk({tag, "_drained"}, v_t'(exp_q.size()), v_t'(0));
    endtask

    task automatic do_reset(input logic en);
        rst = 1'b1;
        i_enable = 1'b0;
        i_instr_ready = 1'b0;
        i_redirect = 1'b0;
        u2_enable = 1'b0;
        u2_ready = 1'b0;
        exp_q.delete();
        rd_log.delete();
        repeat (2) tick();
        i_enable = en;
        rst = 1'b0;
    endtask

    // Memory model: valid rises after mem_lat idle cycles of a held read.
    initial begin
        i_mem_valid = 1'b0;
        mem_data = '0;
        err_np = 1'b0;
        err_nu = 1'b0;
        wait_cnt = 0;
        forever begin
            tick();
            if (i_mem_valid) begin
                i_mem_valid = 1'b0;
                err_np = 1'b0;
                err_nu = 1'b0;
                wait_cnt = 0;
            end
            if (!o_mem_read || rst) begin
                wait_cnt = 0;
            end else if (wait_cnt >= mem_lat) begin
                i_mem_valid = 1'b1;
                mem_data = data_of(o_mem_address);
                err_nu = err_en && !err_sel && (o_mem_address == err_addr);
                err_np = err_en && err_sel && (o_mem_address == err_addr);
                rd_log.push_back(o_mem_address);
            end else begin
                wait_cnt++;
            end
        end
    end

    // Scoreboard: every accepted head entry must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && o_instr_valid && i_instr_ready && !i_redirect) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", v_t'(exp_q.size()), v_t'(1));
            end else begin
                chk("head", {o_instr_fault, o_instr_ip, o_instr}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gaps;
        int leaks;
        rst = 1'b1;
        i_enable = 1'b0;
        i_instr_ready = 1'b0;
        i_redirect = 1'b0;
        i_redirect_ip = '0;
        u2_enable = 1'b0;
        u2_ready = 1'b0;
        u2_go = 1'b0;
        repeat (3) tick();

        @(negedge clk);
        chk("rst_mem_read", v_t'(o_mem_read), v_t'(0));
        chk("rst_mem_addr", v_t'(o_mem_address), v_t'(0));
        chk("rst_instr_valid", v_t'(o_instr_valid), v_t'(0));
        chk("rst_instr_fault", v_t'(o_instr_fault), v_t'(0));
        chk("rst_state", v_t'(o_state), v_t'(S_IDLE));
        chk("rst_u2_read", v_t'(u2_mem_read), v_t'(0));

        // Fill with 2-cycle memory and no consumer.
        mem_lat = 2;
        tick();
        i_enable = 1'b1;
        rst = 1'b0;
        tick();
        chk("first_read", v_t'(o_mem_read), v_t'(1));
        chk("first_addr", v_t'(o_mem_address), v_t'(0));
        repeat (20) tick();
        chk("full_no_read", v_t'(o_mem_read), v_t'(0));
        chk("full_read_count", v_t'(rd_log.size()), v_t'(4));
        for (int i = 0; i < 4; i++) begin
            chk("fill_addr", v_t'(rd_log[i]), v_t'(i * 8));
        end
        chk("full_head_ip", v_t'(o_instr_ip), v_t'(0));
        exp_push(32'h0, 1'b0);
        i_instr_ready = 1'b1;
        tick();
        i_instr_ready = 1'b0;
        chk("refill_read", v_t'(o_mem_read), v_t'(1));
        chk("refill_addr", v_t'(o_mem_address), v_t'(32'h20));
        chk("refill_head_ip", v_t'(o_instr_ip), v_t'(32'h8));

        // Zero-wait streaming with an always-ready consumer.
        mem_lat = 0;
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) exp_push(32'(i * 8), 1'b0);
        i_instr_ready = 1'b1;
        gaps = 0;
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (exp_q.size() == 0) break;
            if (!o_mem_read) gaps++;
        end
        i_instr_ready = 1'b0;
        i_enable = 1'b0;
        chk("stream_gaps", v_t'(gaps), v_t'(0));
        chk("stream_left", v_t'(exp_q.size()), v_t'(0));

        // Redirect while the read of 0x10 is outstanding.
        mem_lat = 2;
        do_reset(1'b1);
        n = 0;
        while (!(o_mem_read && o_mem_address == 32'h10) && n < 50) begin
            tick();
            n++;
        end
        chk("redir_pre_addr", v_t'(o_mem_address), v_t'(32'h10));
        chk("redir_pre_valid", v_t'(o_instr_valid), v_t'(1));
        i_redirect = 1'b1;
        i_redirect_ip = 32'h1003;
        exp_q.delete();
        tick();
        i_redirect = 1'b0;
        chk("redir_flush", v_t'(o_instr_valid), v_t'(0));
        chk("redir_discard", v_t'(o_state), v_t'(S_DISCARD));
        chk("redir_hold_addr", v_t'(o_mem_address), v_t'(32'h10));
        leaks = 0;
        n = 0;
        while (!(o_mem_read && o_mem_address == 32'h1000) && n < 20) begin
            tick();
            n++;
            if (o_instr_valid) leaks++;
        end
        chk("redir_new_addr", v_t'(o_mem_address), v_t'(32'h1000));
        chk("redir_no_push", v_t'(leaks), v_t'(0));
        exp_push(32'h1000, 1'b0);
        drain("redir");

        // Redirect on the very cycle a read completes: data dropped.
        n = 0;
        while (n < 20) begin
            tick();
            #1;
            n++;
            if (i_mem_valid && o_state == 2'd1) break;
        end
        i_redirect = 1'b1;
        i_redirect_ip = 32'h2000;
        exp_q.delete();
        tick();
        i_redirect = 1'b0;
        chk("redir_valid_state", v_t'(o_state), v_t'(S_IDLE));
        chk("redir_valid_empty", v_t'(o_instr_valid), v_t'(0));
        tick();
        chk("redir_valid_addr", v_t'(o_mem_address), v_t'(32'h2000));

        // Not-user fault at 0x18.
        mem_lat = 1;
        err_en = 1'b1;
        err_sel = 1'b0;
        err_addr = 32'h18;
        do_reset(1'b1);
        n = 0;
        while (o_state != S_HALT && n < 50) begin
            tick();
            n++;
        end
        chk("halt_state", v_t'(o_state), v_t'(S_HALT));
        chk("halt_no_read", v_t'(o_mem_read), v_t'(0));
        exp_push(32'h0, 1'b0);
        exp_push(32'h8, 1'b0);
        exp_push(32'h10, 1'b0);
        exp_push(32'h18, 1'b1);
        drain("fault_nu");
        repeat (5) tick();
        chk("halt_reads", v_t'(rd_log.size()), v_t'(4));
        chk("halt_still", v_t'(o_state), v_t'(S_HALT));

        // Not-present fault at 0x8, zero-wait.
        mem_lat = 0;
        err_sel = 1'b1;
        err_addr = 32'h8;
        do_reset(1'b1);
        repeat (6) tick();
        chk("np_halt", v_t'(o_state), v_t'(S_HALT));
        exp_push(32'h0, 1'b0);
        exp_push(32'h8, 1'b1);
        drain("fault_np");

        // Leave HALT by redirect to an unaligned address near the top.
        err_en = 1'b0;
        i_redirect = 1'b1;
        i_redirect_ip = 32'hFFFF_FFF9;
        tick();
        i_redirect = 1'b0;
        chk("wrap_idle", v_t'(o_state), v_t'(S_IDLE));
        exp_push(32'hFFFF_FFF8, 1'b0);
        exp_push(32'h0, 1'b0);
        exp_push(32'h8, 1'b0);
        drain("wrap");
        i_enable = 1'b0;

        // Reset mid-read with two entries queued.
        mem_lat = 2;
        do_reset(1'b1);
        n = 0;
        while (!(o_mem_read && o_mem_address == 32'h10) && n < 50) begin
            tick();
            n++;
        end
        chk("mid_rst_queued", v_t'(o_instr_valid), v_t'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_read", v_t'(o_mem_read), v_t'(0));
        chk("mid_rst_valid", v_t'(o_instr_valid), v_t'(0));
        chk("mid_rst_addr", v_t'(o_mem_address), v_t'(0));
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_restart", v_t'(o_mem_read), v_t'(1));
        chk("mid_rst_addr0", v_t'(o_mem_address), v_t'(0));
        exp_push(32'h0, 1'b0);
        drain("mid_rst");

        // DEPTH=8, INSTR_W=32 instance: 4-byte steps, 8 entries.
        do_reset(1'b0);
        u2_enable = 1'b1;
        u2_go = 1'b1;
        repeat (20) tick();
        chk("u2_full_read", v_t'(u2_mem_read), v_t'(0));
        chk("u2_full_valid", v_t'(u2_instr_valid), v_t'(1));
        u2_enable = 1'b0;
        u2_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("u2_valid", v_t'(u2_instr_valid), v_t'(1));
            chk("u2_ip", v_t'(u2_instr_ip), v_t'(i * 4));
            chk("u2_instr", v_t'(u2_instr), v_t'(32'(i * 4) ^ 32'h5A5A_0000));
            tick();
        end
        u2_ready = 1'b0;
        @(negedge clk);
        chk("u2_empty", v_t'(u2_instr_valid), v_t'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
